conditional_sum_subtractor_serial: RTL and testbench
====================================================

// Module: conditional_sum_subtractor_serial
// PURPOSE
//  Multi-cycle WIDTH-bit subtractor: D = A - B - B_in, one 4-bit conditional-sum slice per clock.
//  Per slice, both borrow-in cases are computed and one is selected by the registered borrow.
//  Complements the combinational conditional-sum adder.
//  Valid/ready on both sides; used where a wide, fully-parallel subtract is too large.
// PARAMETERS
//  WIDTH   16   operand/result width; must be a multiple of 4 (>=4); SLICES = WIDTH/4
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands valid
//  in_ready   out  1      block can accept operands
//  a          in   WIDTH  minuend, unsigned (two's-complement for overflow)
//  b          in   WIDTH  subtrahend
//  b_in       in   1      borrow in
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  d          out  WIDTH  difference, modulo 2^WIDTH
//  b_out      out  1      borrow out: 1 iff a < b + b_in (unsigned)
//  ovf        out  1      signed overflow (only with SUB_OVERFLOW_EN)
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1, out_valid=0, d=0, b_out=0, ovf=0; slice index=0; operand regs=0.
//  FSM IDLE -> BUSY -> DONE -> IDLE.
//   IDLE: in_ready=1. On in_valid&&in_ready: latch a, b, b_in; borrow_r<=b_in; idx<=0; go to BUSY.
//   BUSY: in_ready=0. Each cycle, slice idx computes bits [4*idx+3:4*idx]:
//    - diff0/bor0 (borrow-in 0) and diff1/bor1 (borrow-in 1) are computed in parallel.
//    - borrow_r selects the pair; the selected diff is written into d_r; borrow_r<=selected borrow.
//    - idx<=idx+1.
//    - When idx==SLICES-1: go to DONE.
//   DONE: out_valid=1; d, b_out (=final borrow_r) and ovf are held stable.
//    - On out_ready: go to IDLE.
//  Latency: accept edge to out_valid high = SLICES cycles (16-bit: 4).
//  Throughput: one op per SLICES+2 cycles. No overlap of result handshake with the next accept.
//  d and b_out change only on BUSY slice writes. d holds its last value in IDLE.
//  Backpressure: out_ready low keeps DONE indefinitely, outputs stable, in_ready=0.
//  in_valid outside IDLE is ignored (not latched). Operand inputs are don't-care after accept.
//  Wrap-around: 0-1 gives d=all ones, b_out=1. idx wraps only via return to IDLE.
//  Reset mid-operation: asynchronous abort to reset values. The partial result is discarded.
//  WIDTH=4: a single BUSY cycle.
// CONFIGURATION
//  SUB_OVERFLOW_EN defined:
//   - ovf port present: ovf = (a[W-1]^b[W-1]) & (d[W-1]^a[W-1]), from latched operands.
//   - ovf is valid with out_valid and 0 at reset.
//  SUB_OVERFLOW_EN not defined: ovf port and its logic are absent. All else is identical.
// STRUCTURE
//  Package csa_pkg:
//   - SLICE_W=4.
//   - state encoding IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
//   - function clog2 for idx width.
//  Sub-module conditional_sum_subtractor_4bit (combinational):
//   - in: a[3:0], b[3:0], bin.
//   - out: d[3:0], bout.
//   - internally forms both borrow cases and muxes on bin.
//  Top holds the FSM, idx counter, operand/result registers and the handshake.
// TESTING (WIDTH=16 unless noted)
//  1. a=16'h1234, b=16'h0034, b_in=0 -> d=16'h1200, b_out=0; out_valid exactly 4 cycles after accept.
//  2. a=16'h0000, b=16'h0001, b_in=0 -> d=16'hFFFF, b_out=1. Also a=5, b=5, b_in=1 -> d=16'hFFFF, b_out=1.
//  3. SUB_OVERFLOW_EN: a=16'h8000, b=16'h0001 -> d=16'h7FFF, ovf=1, b_out=0. a=16'h7FFF, b=16'hFFFF -> d=16'h8000, ovf=1.
//  4. Backpressure: hold out_ready=0 for 5 cycles in DONE -> d/b_out stable; in_ready=0; in_valid pulses not latched.
//  5. Deassert rst_n in the 2nd BUSY cycle -> all outputs at reset values immediately. After release: IDLE, in_ready=1.
//  6. 1000 random a, b, b_in at WIDTH=16 and WIDTH=4, random out_ready -> every result matches {b_out,d} = {1'b0,a}-b-b_in.

Source files
------------

// File: rtl/conditional_sum_subtractor_serial_pkg.sv
// Package csa_pkg: shared constants, FSM state type and helper function for
// the serial conditional-sum subtractor and its 4-bit slice.
//   SLICE_W : bits resolved per clock
//   state_t : IDLE / BUSY / DONE
//   clog2   : index width helper, never returns less than 1
package csa_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Minimum of 1 so a single-slice build still has a legal counter width.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/conditional_sum_subtractor_4bit.sv
// Combinational 4-bit conditional-sum subtract slice.
// Both borrow-in cases are formed independently and bin selects the pair.
// Ports:
//   a, b  : 4-bit minuend / subtrahend
//   bin   : borrow in
//   d     : 4-bit difference
//   bout  : borrow out
module conditional_sum_subtractor_4bit
  import csa_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               bin,
  output logic [SLICE_W-1:0] d,
  output logic               bout
);

  // MSB of each (SLICE_W+1)-bit result is the borrow: it is set exactly
  // when the true difference is negative.
  logic [SLICE_W:0] r0;
  logic [SLICE_W:0] r1;

  assign r0 = {1'b0, a} - {1'b0, b};
  assign r1 = {1'b0, a} - {1'b0, b} - (SLICE_W+1)'(1);

  assign {bout, d} = bin ? r1 : r0;

endmodule

// File: rtl/conditional_sum_subtractor_serial.sv
// Multi-cycle WIDTH-bit subtractor: d = a - b - b_in, one 4-bit
// conditional-sum slice per clock, least-significant slice first.
// Optional feature macro: SUB_OVERFLOW_EN (adds the signed-overflow port ovf).
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready : operand handshake (accept only in IDLE)
//   a, b, b_in          : minuend, subtrahend, borrow in
//   out_valid/out_ready : result handshake (result held in DONE)
//   d, b_out            : difference mod 2^WIDTH, unsigned borrow out
//   ovf                 : signed overflow (SUB_OVERFLOW_EN only)
module conditional_sum_subtractor_serial
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             b_out
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned SLICES = WIDTH / SLICE_W;
  localparam int unsigned IDX_W  = clog2(SLICES);

  state_t               state_q,  state_d;
  logic [IDX_W-1:0]     idx_q,    idx_d;
  logic [WIDTH-1:0]     a_q,      a_d;
  logic [WIDTH-1:0]     b_q,      b_d;
  logic                 borrow_q, borrow_d;
  logic [WIDTH-1:0]     d_q,      d_d;
  logic                 bout_q,   bout_d;

  logic [SLICE_W-1:0]   sl_a;
  logic [SLICE_W-1:0]   sl_b;
  logic [SLICE_W-1:0]   sl_d;
  logic                 sl_bout;

  assign sl_a = a_q[idx_q*SLICE_W +: SLICE_W];
  assign sl_b = b_q[idx_q*SLICE_W +: SLICE_W];

  conditional_sum_subtractor_4bit u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .bin  (borrow_q),
    .d    (sl_d),
    .bout (sl_bout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      d_q      <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      d_q      <= d_d;
      bout_q   <= bout_d;
    end
  end

  // b_out is a separate register from the running borrow so that it only
  // moves on slice writes, not when b_in is loaded at accept.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    d_d      = d_q;
    bout_d   = bout_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          borrow_d = b_in;
          idx_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        d_d[idx_q*SLICE_W +: SLICE_W] = sl_d;
        borrow_d = sl_bout;
        bout_d   = sl_bout;
        idx_d    = idx_q + 1'b1;
        if (idx_q == IDX_W'(SLICES - 1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign d         = d_q;
  assign b_out     = bout_q;

`ifdef SUB_OVERFLOW_EN
  // Operands of differing sign whose result sign differs from the minuend.
  assign ovf = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (d_q[WIDTH-1] ^ a_q[WIDTH-1]);
`endif

endmodule

// File: tb/tb_conditional_sum_subtractor_serial.sv
module tb_conditional_sum_subtractor_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid16, in_valid4;
  logic        in_ready16, in_ready4;
  logic [15:0] a_drv, b_drv;
  logic        bin_drv;
  logic        out_valid16, out_valid4;
  logic        out_ready;
  logic [15:0] d16;
  logic [3:0]  d4;
  logic        bout16, bout4;
  logic        ovf16, ovf4;

  int n_err   = 0;
  int n_check = 0;
  bit sel_w4  = 1'b0;

  logic        cur_in_ready, cur_out_valid, cur_bout, cur_ovf;
  logic [15:0] cur_d;

  always #5 clk = ~clk;

  conditional_sum_subtractor_serial #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .a         (a_drv),
    .b         (b_drv),
    .b_in      (bin_drv),
    .out_valid (out_valid16),
    .out_ready (out_ready),
    .d         (d16),
    .b_out     (bout16)
`ifdef SUB_OVERFLOW_EN
    ,
    .ovf       (ovf16)
`endif
  );

  conditional_sum_subtractor_serial #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .a         (a_drv[3:0]),
    .b         (b_drv[3:0]),
    .b_in      (bin_drv),
    .out_valid (out_valid4),
    .out_ready (out_ready),
    .d         (d4),
    .b_out     (bout4)
`ifdef SUB_OVERFLOW_EN
    ,
    .ovf       (ovf4)
`endif
  );

`ifndef SUB_OVERFLOW_EN
  assign ovf16 = 1'b0;
  assign ovf4  = 1'b0;
`endif

  assign cur_in_ready  = sel_w4 ? in_ready4  : in_ready16;
  assign cur_out_valid = sel_w4 ? out_valid4 : out_valid16;
  assign cur_d         = sel_w4 ? {12'h000, d4} : d16;
  assign cur_bout      = sel_w4 ? bout4 : bout16;
  assign cur_ovf       = sel_w4 ? ovf4  : ovf16;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_check++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on w-bit operands.
  // Returns {ovf, borrow, d}.
  function automatic logic [17:0] model(input int unsigned w, input logic [15:0] a,
                                        input logic [15:0] b, input logic bin);
    longint m, ua, ub, diff, sa, sb, sr;
    logic [15:0] dd;
    logic bo, ov;
    m    = longint'(1) << w;
    ua   = longint'(a) & (m - 1);
    ub   = longint'(b) & (m - 1);
    diff = ua - ub - longint'(bin);
    bo   = (diff < 0);
    dd   = 16'((diff + m) % m);
    sa   = (ua >= m / 2) ? ua - m : ua;
    sb   = (ub >= m / 2) ? ub - m : ub;
    sr   = sa - sb - longint'(bin);
    ov   = (sr >= m / 2) || (sr < -(m / 2));
    return {ov, bo, dd};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One complete transaction on the selected DUT; returns the result and
  // the accept-to-out_valid latency in cycles.
  task automatic op(input bit w4, input logic [15:0] ai, input logic [15:0] bi,
                    input logic bini, input int unsigned rdel,
                    output logic [15:0] dout, output logic bo, output logic ov,
                    output int lat);
    int t;
    sel_w4 = w4;
    #0;
    t = 0;
    while (!cur_in_ready && t < 50) begin tick(); t++; end
    chk("in_ready_wait", 32'(cur_in_ready), 32'd1);
    a_drv   = ai;
    b_drv   = bi;
    bin_drv = bini;
    if (w4) in_valid4 = 1'b1; else in_valid16 = 1'b1;
    tick();
    in_valid4  = 1'b0;
    in_valid16 = 1'b0;
    a_drv   = 16'($urandom);
    b_drv   = 16'($urandom);
    bin_drv = 1'($urandom);
    lat = 0;
    while (!cur_out_valid && lat < 50) begin tick(); lat++; end
    chk("out_valid_wait", 32'(cur_out_valid), 32'd1);
    dout = cur_d;
    bo   = cur_bout;
    ov   = cur_ovf;
    repeat (rdel) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] d;
    logic        bout;
    logic        ovf;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] rd, hold_d;
    logic        rb, ro, hold_b;
    logic [17:0] exp;
    int          lat;

    vecs[0] = '{16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[2] = '{16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vecs[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[8] = '{16'h0000, 16'h8000, 1'b0, 16'h8000, 1'b1, 1'b1};

    rst_n = 1'b0; in_valid16 = 1'b0; in_valid4 = 1'b0; out_ready = 1'b0;
    a_drv = '0; b_drv = '0; bin_drv = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready16), 32'd1);
    chk("rst_out_valid", 32'(out_valid16), 32'd0);
    chk("rst_d", 32'(d16), 32'd0);
    chk("rst_b_out", 32'(bout16), 32'd0);
`ifdef SUB_OVERFLOW_EN
    chk("rst_ovf", 32'(ovf16), 32'd0);
`endif
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Directed vectors at WIDTH=16
    for (int i = 0; i < 9; i++) begin
      op(1'b0, vecs[i].a, vecs[i].b, vecs[i].bin, 0, rd, rb, ro, lat);
      chk($sformatf("vec%0d_d", i), 32'(rd), 32'(vecs[i].d));
      chk($sformatf("vec%0d_b_out", i), 32'(rb), 32'(vecs[i].bout));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
`ifdef SUB_OVERFLOW_EN
      chk($sformatf("vec%0d_ovf", i), 32'(ro), 32'(vecs[i].ovf));
`endif
    end

    // WIDTH=4: single BUSY cycle, wrap-around
    op(1'b1, 16'h0000, 16'h0001, 1'b0, 0, rd, rb, ro, lat);
    chk("w4_wrap_d", 32'(rd), 32'h0000000F);
    chk("w4_wrap_b_out", 32'(rb), 32'd1);
    chk("w4_latency", 32'(lat), 32'd1);

    // Backpressure: DONE held, outputs stable, in_valid pulses ignored
    sel_w4 = 1'b0;
    a_drv = 16'hABCD; b_drv = 16'h1234; bin_drv = 1'b0;
    in_valid16 = 1'b1;
    tick();
    in_valid16 = 1'b0;
    repeat (4) tick();
    chk("bp_out_valid", 32'(out_valid16), 32'd1);
    hold_d = d16; hold_b = bout16;
    chk("bp_d", 32'(hold_d), 32'h00009999);
    chk("bp_b_out", 32'(hold_b), 32'd0);
    for (int i = 0; i < 5; i++) begin
      a_drv = 16'($urandom); b_drv = 16'($urandom); bin_drv = 1'($urandom);
      in_valid16 = 1'b1;
      tick();
      chk("bp_hold_d", 32'(d16), 32'h00009999);
      chk("bp_hold_b_out", 32'(bout16), 32'd0);
      chk("bp_in_ready", 32'(in_ready16), 32'd0);
      chk("bp_out_valid_held", 32'(out_valid16), 32'd1);
    end
    in_valid16 = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_idle_in_ready", 32'(in_ready16), 32'd1);
    chk("bp_idle_out_valid", 32'(out_valid16), 32'd0);
    chk("bp_idle_d_held", 32'(d16), 32'h00009999);

    // Reset during the second BUSY cycle
    a_drv = 16'hFFF0; b_drv = 16'h0001; bin_drv = 1'b0;
    in_valid16 = 1'b1;
    tick();
    in_valid16 = 1'b0;
    tick();
    chk("abort_partial_b_out", 32'(bout16), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_d", 32'(d16), 32'd0);
    chk("abort_b_out", 32'(bout16), 32'd0);
    chk("abort_out_valid", 32'(out_valid16), 32'd0);
    chk("abort_in_ready", 32'(in_ready16), 32'd1);
`ifdef SUB_OVERFLOW_EN
    chk("abort_ovf", 32'(ovf16), 32'd0);
`endif
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_abort_in_ready", 32'(in_ready16), 32'd1);
    chk("post_abort_out_valid", 32'(out_valid16), 32'd0);
    op(1'b0, 16'h0100, 16'h0001, 1'b1, 0, rd, rb, ro, lat);
    chk("post_abort_d", 32'(rd), 32'h000000FE);
    chk("post_abort_b_out", 32'(rb), 32'd0);

    // Randomized against the reference model, both widths
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 1000; i++) begin
        logic [15:0] ra, rbb;
        logic        rbin;
        ra   = 16'($urandom);
        rbb  = 16'($urandom);
        rbin = 1'($urandom);
        if (w == 1) begin ra[15:4] = '0; rbb[15:4] = '0; end
        exp = model((w == 1) ? 4 : 16, ra, rbb, rbin);
        op(w == 1, ra, rbb, rbin, $urandom_range(0, 3), rd, rb, ro, lat);
        chk("rand_d", 32'(rd), 32'(exp[15:0]));
        chk("rand_b_out", 32'(rb), 32'(exp[16]));
`ifdef SUB_OVERFLOW_EN
        chk("rand_ovf", 32'(ro), 32'(exp[17]));
`endif
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_check);
    $finish;
  end

endmodule
